// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared definitions for the AES-128 inverse key generator:
//               default round count, round-constant table, round-key
//               word/byte/key typedefs and the FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    // Number of AES-128 rounds
    localparam int unsigned NR = 10;

    typedef logic [7:0]       aes_byte_t;
    typedef logic [31:0]      aes_word_t;
    // Word 0 is the most significant word; byte 0 of a word sits in [31:24]
    typedef logic [0:3][31:0] aes_key_t;

    // Round constants indexed by round number; entries 0 and 11..15 are
    // never used and are tied to zero
    localparam logic [0:15][7:0] C_RCON = {
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        SUB  = 2'd2
    } state_t;

endpackage : aes_pkg
`default_nettype wire

// File: rtl/aes_sbox_word.sv
`default_nettype none
// ============================================================================
// Module      : aes_sbox_word
// Description : Purely combinational AES forward S-box applied to each of the
//               four bytes of a 32-bit word.
// Ports       : i_word  - 32-bit input word
//               o_word  - 32-bit word with every byte substituted
// Revision    : 1.0 - initial release
// ============================================================================
module aes_sbox_word (
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);
    import aes_pkg::*;

    // Row-major table: element 0 is the leftmost byte of the first row
    localparam logic [0:255][7:0] C_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    for (genvar i = 0; i < 4; i++) begin : g_byte
        assign o_word[8*i +: 8] = C_SBOX[i_word[8*i +: 8]];
    end

endmodule : aes_sbox_word
`default_nettype wire

// File: rtl/aes_inv_key_gen.sv
`default_nettype none
// ============================================================================
// Module      : aes_inv_key_gen
// Description : AES-128 inverse key schedule. Accepts the last round key and
//               emits round keys NR, NR-1, ..., 0 (round 0 is the cipher key)
//               over a valid/ready interface, one key every two cycles when
//               the consumer never stalls.
// Ports       : clk        - clock, rising edge
//               nrst       - synchronous active-low reset
//               clear      - synchronous abort back to IDLE
//               in_valid   - in_key carries the round-NR key
//               in_ready   - block can accept in_key (IDLE only)
//               in_key     - round-NR key, word 0 first
//               out_valid  - out_key/out_round carry a round key
//               out_ready  - consumer accepts out_key
//               out_key    - current round key
//               out_round  - round index of out_key
//               busy       - high outside IDLE
//               done       - one-cycle pulse after round 0 is accepted
// Revision    : 1.0 - initial release
// ============================================================================
module aes_inv_key_gen #(
    parameter int unsigned NR = aes_pkg::NR
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            clear,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [0:3][31:0] in_key,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [0:3][31:0] out_key,
    output logic [3:0]      out_round,
    output logic            busy,
    output logic            done
);
    import aes_pkg::*;

    state_t    r_state;
    aes_key_t  r_key;
    logic [3:0] r_round;
    logic      r_done;

    aes_word_t w_w0;
    aes_word_t w_w1;
    aes_word_t w_w2;
    aes_word_t w_w3;
    aes_word_t w_rot;
    aes_word_t w_sub;
    aes_key_t  w_prev_key;

    // Undo one forward-expansion step. Words 1..3 of the previous round key
    // are XORs of adjacent words; word 3 of the previous key is the word the
    // forward schedule fed through RotWord/SubWord, so it is recovered first.
    assign w_w3  = r_key[3] ^ r_key[2];
    assign w_w2  = r_key[2] ^ r_key[1];
    assign w_w1  = r_key[1] ^ r_key[0];
    assign w_rot = {w_w3[23:0], w_w3[31:24]};

    aes_sbox_word u_sbox (
        .i_word (w_rot),
        .o_word (w_sub)
    );

    // Rcon is indexed by the round being left, not the round being entered
    assign w_w0       = r_key[0] ^ w_sub ^ {C_RCON[r_round], 24'h000000};
    assign w_prev_key = {w_w0, w_w1, w_w2, w_w3};

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state <= IDLE;
            r_key   <= '0;
            r_round <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (clear) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (in_valid) begin
                            r_key   <= in_key;
                            r_round <= 4'(NR);
                            r_state <= EMIT;
                        end
                    end
                    EMIT: begin
                        if (out_ready) begin
                            if (r_round == 4'd0) begin
                                r_state <= IDLE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= SUB;
                            end
                        end
                    end
                    SUB: begin
                        r_key   <= w_prev_key;
                        r_round <= r_round - 4'd1;
                        r_state <= EMIT;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    // All outputs come from registers or a decode of the state register
    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign out_valid = (r_state == EMIT);
    assign out_key   = r_key;
    assign out_round = r_round;
    assign done      = r_done;

endmodule : aes_inv_key_gen
`default_nettype wire

// File: tb/tb_aes_inv_key_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_inv_key_gen
// Description : Self-checking bench for aes_inv_key_gen. A reference AES-128
//               forward key expansion (S-box derived from GF(2^8) inversion
//               and the affine map) supplies the expected round keys.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_inv_key_gen;

    typedef logic [127:0] k128_t;

    logic             clk;
    logic             nrst;
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [0:3][31:0] in_key;
    logic             out_valid;
    logic             out_ready;
    logic [0:3][31:0] out_key;
    logic [3:0]       out_round;
    logic             busy;
    logic             done;

    int n_checks;
    int n_fail;

    logic [7:0] sbox_ref [0:255];
    k128_t      rk [0:10];

    aes_inv_key_gen #(.NR(10)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_key   (out_key),
        .out_round (out_round),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int s);
        return (v << s) | (v >> (8 - s));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
            if (x == 0) inv = 8'h00;
            sbox_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox_ref[w[31:24]], sbox_ref[w[23:16]], sbox_ref[w[15:8]], sbox_ref[w[7:0]]};
    endfunction

    // Forward expansion: rk[r] is the round-r key, word 0 in bits [127:96]
    task automatic expand(input k128_t ck);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = ck[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic k128_t rand_key();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- stimulus helpers ----------------
    // Called at a negedge; returns 1 ns after the accepting posedge
    task automatic start(input k128_t k);
        int t;
        t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("accept_ready", 128'(in_ready), 128'(1));
        in_valid = 1'b1;
        in_key   = k;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // mode 0: always ready, 1: random ready, 2: 5-cycle stall on round 7
    task automatic run_seq(input int mode, input bit hold_iv, input k128_t other);
        int  expr;
        int  stall;
        bit  seen_done;
        start(rk[10]);
        if (hold_iv) begin
            in_valid = 1'b1;
            in_key   = other;
        end
        expr = 10; stall = 0; seen_done = 1'b0;
        for (int n = 0; n < 400 && !seen_done; n++) begin
            @(negedge clk);
            if (done) begin
                chk("all_keys_before_done", 128'(expr == -1), 128'(1));
                seen_done = 1'b1;
            end else begin
                case (mode)
                    0: out_ready = 1'b1;
                    1: out_ready = ($urandom_range(0, 3) != 0);
                    default: begin
                        if (out_valid && out_round == 4'd7 && stall < 5) begin
                            out_ready = 1'b0;
                            stall++;
                        end else begin
                            out_ready = 1'b1;
                        end
                    end
                endcase
                if (hold_iv) chk("in_ready_low_busy", 128'(in_ready), 128'(0));
                if (out_valid) begin
                    chk("out_round", 128'(out_round), 128'(expr));
                    chk("out_key", out_key, rk[expr < 0 ? 0 : expr]);
                    if (out_ready) begin
                        if (expr == 0) in_valid = 1'b0;
                        expr--;
                    end
                end
            end
        end
        chk("seq_done_seen", 128'(seen_done), 128'(1));
        if (mode == 2) chk("stall_cycles", 128'(stall), 128'(5));
        in_valid = 1'b0;
        @(negedge clk);
        chk("done_single_pulse", 128'(done), 128'(0));
        chk("idle_after_seq", 128'(in_ready), 128'(1));
    endtask

    localparam k128_t FIPS_CK  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam k128_t FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam k128_t FIPS_R9  = 128'hac7766f319fadc2128d12941575c006e;

    initial begin
        int t;
        n_checks = 0; n_fail = 0;
        nrst = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_key = '0;
        build_sbox();

        // ---- reset ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_busy",      128'(busy),      128'(0));
        chk("rst_done",      128'(done),      128'(0));
        chk("rst_out_key",   out_key,         128'(0));
        chk("rst_out_round", 128'(out_round), 128'(0));
        nrst = 1'b1;
        @(negedge clk);
        chk("rst_in_ready",  128'(in_ready),  128'(1));

        // ---- FIPS-197 A.1 with exact cycle timing ----
        expand(FIPS_CK);
        out_ready = 1'b1;
        start(FIPS_R10);
        for (int n = 0; n <= 21; n++) begin
            @(negedge clk);
            chk("fips_out_valid", 128'(out_valid), 128'((n % 2 == 0) && (n <= 20)));
            chk("fips_done",      128'(done),      128'(n == 21));
            if ((n % 2 == 0) && (n <= 20)) begin
                chk("fips_round", 128'(out_round), 128'(10 - n/2));
                chk("fips_key",   out_key,         rk[10 - n/2]);
            end
            if (n == 0)  chk("fips_r10_echo", out_key, FIPS_R10);
            if (n == 2)  chk("fips_r9",       out_key, FIPS_R9);
            if (n == 20) chk("fips_r0",       out_key, FIPS_CK);
        end
        @(negedge clk);
        chk("fips_done_once", 128'(done), 128'(0));

        // ---- backpressure on round 7 ----
        run_seq(2, 1'b0, '0);

        // ---- in_valid held with another key while busy ----
        run_seq(0, 1'b1, rand_key());
        expand(rand_key());
        run_seq(0, 1'b0, '0);

        // ---- clear at round 4 ----
        expand(rand_key());
        out_ready = 1'b1;
        start(rk[10]);
        t = 0;
        @(negedge clk);
        while (!(out_valid && out_round == 4'd4) && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("clear_reached_r4", 128'(out_valid && out_round == 4'd4), 128'(1));
        clear = 1'b1; in_valid = 1'b1; in_key = rand_key();
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;
        chk("clear_out_valid", 128'(out_valid), 128'(0));
        chk("clear_busy",      128'(busy),      128'(0));
        chk("clear_done",      128'(done),      128'(0));
        @(negedge clk);
        chk("clear_no_done",   128'(done),      128'(0));
        // clear in IDLE blocks a simultaneous in_valid
        clear = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;
        chk("clear_blocks_accept", 128'(busy), 128'(0));
        expand(rand_key());
        run_seq(0, 1'b0, '0);

        // ---- reset during SUB ----
        expand(rand_key());
        out_ready = 1'b1;
        start(rk[10]);
        @(negedge clk);
        chk("pre_rst_emit", 128'(out_valid), 128'(1));
        @(negedge clk);
        chk("pre_rst_sub", 128'({busy, out_valid}), 128'(2'b10));
        nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        chk("mrst_out_valid", 128'(out_valid), 128'(0));
        chk("mrst_busy",      128'(busy),      128'(0));
        chk("mrst_done",      128'(done),      128'(0));
        chk("mrst_out_key",   out_key,         128'(0));
        chk("mrst_out_round", 128'(out_round), 128'(0));
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("mrst_in_ready",   128'(in_ready),  128'(1));
            chk("mrst_no_valid",   128'(out_valid), 128'(0));
        end

        // ---- round trip, random keys and random backpressure ----
        for (int k = 0; k < 16; k++) begin
            k128_t ck;
            ck = rand_key();
            expand(ck);
            run_seq(1, 1'b0, '0);
            chk("roundtrip_model_r0", rk[0], ck);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_aes_inv_key_gen
`default_nettype wire
